ex_mem_stage: RTL
=================

Name: ex_mem_stage

Overview:
- EX/MEM pipeline register fused with the data-memory access controller of the 16-bit pipelined CPU.
- Captures the EX stage result and control each cycle, and runs the data-memory read/write handshake with variable-latency acknowledge.
- Stalls upstream stages while a memory access is outstanding and produces the MEM/WB register contents for write-back.
- Also exposes EX/MEM contents to the forwarding unit.

Parameters:
- WORD_SIZE, 16, datapath width.
- MAX_WAIT, 15, maximum ACCESS cycles without d_ack before a timeout is declared (1..255).

Ports:
- clk  in  1  clock, posedge.
- reset_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX holds a real instruction (0 = bubble).
- ex_PC  in  WORD_SIZE  instruction PC.
- ex_alu_result  in  WORD_SIZE  ALU result / memory address / wwd value.
- ex_store_data  in  WORD_SIZE  forwarded rt value for stores.
- ex_rd  in  2  destination register.
- ex_MemRead, ex_MemWrite  in  1 each  memory control.
- ex_RegWrite, ex_MemtoReg, ex_is_wwd  in  1 each  write-back control.
- d_ack  in  1  data memory completes current request this cycle.
- d_data_in  in  WORD_SIZE  read data, valid when d_ack=1 on a read.
- d_readM, d_writeM  out  1 each  memory request strobes.
- d_address  out  WORD_SIZE  memory address.
- d_data_out  out  WORD_SIZE  store data.
- mem_stall  out  1  freeze PC, IF/ID, ID/EX this cycle.
- fwd_rd  out  2  EX/MEM destination register.
- fwd_RegWrite  out  1  EX/MEM forwarding enable.
- fwd_data  out  WORD_SIZE  EX/MEM forwarding value.
- wb_valid, wb_RegWrite, wb_is_wwd  out  1 each  MEM/WB control.
- wb_rd  out  2  MEM/WB destination register.
- wb_data  out  WORD_SIZE  write-back value.
- wb_PC  out  WORD_SIZE  MEM/WB PC.
- mem_error  out  1  sticky timeout flag.

Behaviour:
- Reset (async, reset_n low): all EX/MEM and MEM/WB fields 0, state IDLE, wait_cnt 0, mem_error 0. All outputs 0, including d_readM/d_writeM; a request in progress is dropped immediately. First capture occurs at the first posedge after deassertion.
- EX/MEM register (m_*):
  - Loads all ex_* fields at posedge when mem_stall=0; holds when mem_stall=1.
  - If ex_MemRead and ex_MemWrite are both 1, it is treated as a read.
- FSM:
  - IDLE: at posedge with mem_stall=0, if ex_valid & (ex_MemRead|ex_MemWrite) go to ACCESS with wait_cnt=0; else stay IDLE.
  - ACCESS, d_ack=1: access completes. At this posedge either load a new memory op (re-enter ACCESS, wait_cnt=0) or go to IDLE.
  - ACCESS, d_ack=0: wait_cnt++. If wait_cnt==MAX_WAIT-1 at that edge, timeout: set mem_error, complete the access as failed, leave ACCESS by the same rules as ack.
- Memory outputs:
  - d_readM = (state==ACCESS) & m_MemRead.
  - d_writeM = (state==ACCESS) & m_MemWrite & ~m_MemRead.
  - d_address = m_alu_result; d_data_out = m_store_data. Both stable throughout ACCESS.
- mem_stall = (state==ACCESS) & ~d_ack & ~timeout_now (combinational).
- Forwarding:
  - fwd_rd = m_rd.
  - fwd_RegWrite = m_valid & m_RegWrite & ~m_MemtoReg; loads are not forwardable from this stage.
  - fwd_data = m_alu_result.
- MEM/WB update at each posedge:
  - If mem_stall=1: wb_valid, wb_RegWrite, wb_is_wwd <= 0 (bubble).
  - Else: wb_valid <= m_valid; wb_rd, wb_PC, wb_is_wwd copied.
  - wb_data <= (m_MemtoReg ? d_data_in : m_alu_result).
  - On a failed (timeout) access: wb_data <= 0 and wb_RegWrite <= 0; otherwise wb_RegWrite <= m_valid & m_RegWrite.
- Latency:
  - Non-memory instruction: 1 cycle EX/MEM to MEM/WB.
  - Memory access acked in its first ACCESS cycle: 1 cycle, zero stall.
  - Each non-ack cycle adds exactly one stall cycle.
- Back-to-back memory ops: the second enters ACCESS on the ack edge of the first, with no IDLE gap.
- Bubbles (ex_valid=0) never start an access, regardless of the Mem bits.

Test Plan:
- Reset mid-ACCESS with d_readM=1: assert reset_n=0 -> d_readM=0, mem_stall=0, wb_valid=0 immediately; after release, first instruction flows normally.
- ALU op, ex_alu_result=16'h1234, rd=2, RegWrite=1 -> next edge fwd_data=16'h1234, fwd_RegWrite=1; following edge wb_data=16'h1234, wb_rd=2, wb_RegWrite=1, mem_stall never 1.
- Load addr 16'h0040, d_ack asserted after 3 cycles with d_data_in=16'hBEEF -> d_readM=1, d_address=16'h0040 for 3 cycles, mem_stall=1 for 2 cycles, then wb_data=16'hBEEF, wb_RegWrite=1.
- Store addr 16'h0010 data 16'h00AA followed immediately by load 16'h0011, both acked same cycle -> d_writeM one cycle, then d_readM next cycle, no stall, wb_RegWrite=0 for the store, wb_valid=1 for both.
- Load with d_ack held 0, MAX_WAIT=4 -> mem_stall=1 for 3 cycles, then mem_error=1 (sticky), wb_data=0, wb_RegWrite=0, wb_valid=1, pipeline resumes.
- Bubble with ex_MemWrite=1, ex_valid=0 -> d_writeM stays 0, wb_valid=0.

Source files
------------

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register fused with the data-memory access controller
//
// Captures EX results and control into the EX/MEM register, runs the data
// memory request/acknowledge handshake (with a bounded wait and a sticky
// timeout flag), stalls upstream stages while an access is outstanding, and
// produces the MEM/WB register for write-back.
//
// Ports:
//   clk, reset_n          clock (posedge), asynchronous active-low reset
//   ex_*                  EX stage instruction, result and control
//   d_ack, d_data_in      data memory completion and read data
//   d_readM, d_writeM     data memory request strobes
//   d_address, d_data_out data memory address and store data
//   mem_stall             freeze PC, IF/ID, ID/EX this cycle
//   fwd_*                 EX/MEM contents for the forwarding unit
//   wb_*                  MEM/WB register contents
//   mem_error             sticky memory timeout flag
module ex_mem_stage #(
    parameter int WORD_SIZE = 16,
    parameter int MAX_WAIT  = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ex_valid,
    input  logic [WORD_SIZE-1:0] ex_PC,
    input  logic [WORD_SIZE-1:0] ex_alu_result,
    input  logic [WORD_SIZE-1:0] ex_store_data,
    input  logic [1:0]           ex_rd,
    input  logic                 ex_MemRead,
    input  logic                 ex_MemWrite,
    input  logic                 ex_RegWrite,
    input  logic                 ex_MemtoReg,
    input  logic                 ex_is_wwd,
    input  logic                 d_ack,
    input  logic [WORD_SIZE-1:0] d_data_in,
    output logic                 d_readM,
    output logic                 d_writeM,
    output logic [WORD_SIZE-1:0] d_address,
    output logic [WORD_SIZE-1:0] d_data_out,
    output logic                 mem_stall,
    output logic [1:0]           fwd_rd,
    output logic                 fwd_RegWrite,
    output logic [WORD_SIZE-1:0] fwd_data,
    output logic                 wb_valid,
    output logic                 wb_RegWrite,
    output logic                 wb_is_wwd,
    output logic [1:0]           wb_rd,
    output logic [WORD_SIZE-1:0] wb_data,
    output logic [WORD_SIZE-1:0] wb_PC,
    output logic                 mem_error
);

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t               state;
    state_t               state_nxt;
    logic [7:0]           wait_cnt;
    logic [7:0]           wait_cnt_nxt;
    logic                 timeout_now;
    logic                 start_access;

    logic                 m_valid;
    logic [WORD_SIZE-1:0] m_PC;
    logic [WORD_SIZE-1:0] m_alu_result;
    logic [WORD_SIZE-1:0] m_store_data;
    logic [1:0]           m_rd;
    logic                 m_MemRead;
    logic                 m_MemWrite;
    logic                 m_RegWrite;
    logic                 m_MemtoReg;
    logic                 m_is_wwd;

    // A timed-out access ends this edge exactly as if it had been acked,
    // so the stall is released in the same cycle the timeout is detected.
    assign timeout_now  = (state == S_ACCESS) && !d_ack && (wait_cnt == WAIT_LAST);
    assign mem_stall    = (state == S_ACCESS) && !d_ack && !timeout_now;
    assign start_access = ex_valid && (ex_MemRead || ex_MemWrite);

    // Read wins when both Mem bits are set.
    assign d_readM      = (state == S_ACCESS) && m_MemRead;
    assign d_writeM     = (state == S_ACCESS) && m_MemWrite && !m_MemRead;
    assign d_address    = m_alu_result;
    assign d_data_out   = m_store_data;

    // Loads deliver data only at write-back, so they are never forwarded here.
    assign fwd_rd       = m_rd;
    assign fwd_RegWrite = m_valid && m_RegWrite && !m_MemtoReg;
    assign fwd_data     = m_alu_result;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Whenever the stall is released the EX/MEM register reloads, so the
    // next state depends only on the newly captured instruction; this gives
    // back-to-back accesses with no IDLE gap.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        if (mem_stall) begin
            wait_cnt_nxt = wait_cnt + 8'd1;
        end else if (start_access) begin
            state_nxt    = S_ACCESS;
            wait_cnt_nxt = '0;
        end else begin
            state_nxt    = S_IDLE;
            wait_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid      <= 1'b0;
            m_PC         <= '0;
            m_alu_result <= '0;
            m_store_data <= '0;
            m_rd         <= '0;
            m_MemRead    <= 1'b0;
            m_MemWrite   <= 1'b0;
            m_RegWrite   <= 1'b0;
            m_MemtoReg   <= 1'b0;
            m_is_wwd     <= 1'b0;
            wb_valid     <= 1'b0;
            wb_RegWrite  <= 1'b0;
            wb_is_wwd    <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            wb_PC        <= '0;
            mem_error    <= 1'b0;
        end else begin
            if (!mem_stall) begin
                m_valid      <= ex_valid;
                m_PC         <= ex_PC;
                m_alu_result <= ex_alu_result;
                m_store_data <= ex_store_data;
                m_rd         <= ex_rd;
                m_MemRead    <= ex_MemRead;
                m_MemWrite   <= ex_MemWrite;
                m_RegWrite   <= ex_RegWrite;
                m_MemtoReg   <= ex_MemtoReg;
                m_is_wwd     <= ex_is_wwd;
            end

            if (timeout_now) begin
                mem_error <= 1'b1;
            end

            if (mem_stall) begin
                wb_valid    <= 1'b0;
                wb_RegWrite <= 1'b0;
                wb_is_wwd   <= 1'b0;
            end else begin
                wb_valid    <= m_valid;
                wb_rd       <= m_rd;
                wb_PC       <= m_PC;
                wb_is_wwd   <= m_is_wwd;
                wb_RegWrite <= timeout_now ? 1'b0 : (m_valid && m_RegWrite);
            end

            if (timeout_now) begin
                wb_data <= '0;
            end else begin
                wb_data <= m_MemtoReg ? d_data_in : m_alu_result;
            end
        end
    end

endmodule
